// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Default encodings, state values and the PC adder live here.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    function automatic logic [31:0] add32(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return a + b;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register with hold and bubble-insert controls.
// Hold beats bubble; a bubble keeps the previous pc_plus4.
module fetch_stage_if_id_reg #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        bubble,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc_plus4,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr    <= NOP_WORD;
            pc_plus4 <= 32'h0;
            valid    <= 1'b0;
        end else if (hold) begin
            instr    <= instr;
            pc_plus4 <= pc_plus4;
            valid    <= valid;
        end else if (bubble) begin
            instr    <= NOP_WORD;
            valid    <= 1'b0;
        end else begin
            instr    <= next_instr;
            pc_plus4 <= next_pc_plus4;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, feeds IF/ID,
// and freezes permanently on the HALT word until reset.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [0:0]  state;
    logic [0:0]  state_next;
    logic        run;
    logic        in_halt;
    logic        do_redirect;
    logic        do_stall;
    logic        do_wait;
    logic        do_fetch;
    logic        is_halt;
    logic        hold;
    logic        bubble;

    assign pc_plus4  = add32(pc, 32'd4);
    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);

    // One-hot cycle action, in priority order.
    assign run         = (state == ST_RUN);
    assign in_halt     = ~run;
    assign do_redirect = run & redirect_valid;
    assign do_stall    = run & ~redirect_valid & stall;
    assign do_wait     = run & ~redirect_valid & ~stall & ~imem_ready;
    assign do_fetch    = run & ~redirect_valid & ~stall & imem_ready;
    assign is_halt     = (imem_rdata == HALT_WORD);

    always_comb begin
        pc_next    = pc;
        state_next = state;
        unique case (1'b1)
            do_redirect: pc_next = redirect_target;
            do_fetch: begin
                if (is_halt) state_next = ST_HALT;
                else         pc_next    = pc_plus4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= ST_RUN;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    assign hold   = do_stall | (in_halt & stall);
    assign bubble = do_redirect | do_wait | (in_halt & ~stall);

    fetch_stage_if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk           (clk),
        .reset         (reset),
        .hold          (hold),
        .bubble        (bubble),
        .next_instr    (imem_rdata),
        .next_pc_plus4 (pc_plus4),
        .instr         (if_id_instr),
        .pc_plus4      (if_id_pc_plus4),
        .valid         (if_id_valid)
    );

endmodule
